// File: rtl/hash_job_scheduler_pkg.sv
// Shared definitions for the hash job scheduler.
//   NONCE_W       : width of one nonce / slice base
//   sched_state_e : scheduler FSM states
//   clog2()       : ceiling log2, usable in constant expressions
package hash_sched_pkg;

  localparam int unsigned NONCE_W = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDispatch = 2'd1,
    StRun      = 2'd2,
    StReport   = 2'd3
  } sched_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/hash_job_scheduler_if.sv
// Control/result bundle between the USB3 interface, the scheduler and the core array.
//   master : scheduler side (drives core controls and results)
//   slave  : environment side (drives job controls and core indications)
// Signals:
//   start_hash, host_break       : job launch level / abort request
//   core_start, core_base        : per-core start pulse and slice base (core i at [32*i +: 32])
//   core_abort                   : stop all cores
//   core_found, core_done        : per-core find / slice-exhausted pulses
//   core_nonce                   : per-core nonce, valid with core_found
//   nonce, ticket2moon, hash_cmplt, busy : result path and status
interface hash_job_scheduler_if
  import hash_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4
) ();

  logic                           start_hash;
  logic                           host_break;
  logic [NUM_CORES-1:0]           core_start;
  logic [NONCE_W*NUM_CORES-1:0]   core_base;
  logic                           core_abort;
  logic [NUM_CORES-1:0]           core_found;
  logic [NUM_CORES-1:0]           core_done;
  logic [NONCE_W*NUM_CORES-1:0]   core_nonce;
  logic [NONCE_W-1:0]             nonce;
  logic                           ticket2moon;
  logic                           hash_cmplt;
  logic                           busy;

  modport master (
    input  start_hash, host_break, core_found, core_done, core_nonce,
    output core_start, core_base, core_abort, nonce, ticket2moon, hash_cmplt, busy
  );

  modport slave (
    output start_hash, host_break, core_found, core_done, core_nonce,
    input  core_start, core_base, core_abort, nonce, ticket2moon, hash_cmplt, busy
  );

endinterface

// File: rtl/hash_job_scheduler_lsb_priority_enc.sv
// Lowest-index-wins priority encoder.
//   i_req   : request vector (any number of bits set)
//   o_valid : at least one request set
//   o_idx   : index of the lowest set bit (0 when none)
module lsb_priority_enc #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Width-1:0] i_req,
  output logic             o_valid,
  output logic [IdxW-1:0]  o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downward so the lowest set bit is the last to assign.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/hash_job_scheduler.sv
// Splits one hashing job over NUM_CORES cores (disjoint nonce slices) and funnels
// their find/done pulses into a single nonce / ticket2moon / hash_cmplt result.
// Ports:
//   clk_h : system clock
//   rst_n : asynchronous active-low reset
//   bus   : hash_job_scheduler_if.master (job controls, core array, result path)
// Parameters:
//   NUM_CORES : power of two, 1..16
//   NONCE_ADJ : pipeline offset subtracted from the winning nonce
// Build option:
//   HASH_SCHED_NONCE_ADJ_EN : when defined, reported nonce = core nonce - NONCE_ADJ (mod 2^32);
//                             otherwise the core nonce is reported unmodified.
module hash_job_scheduler
  import hash_sched_pkg::*;
#(
  parameter int unsigned        NUM_CORES = 4,
  parameter logic [NONCE_W-1:0] NONCE_ADJ = 32'h88
) (
  input logic                    clk_h,
  input logic                    rst_n,
  hash_job_scheduler_if.master   bus
);

  localparam int unsigned Log2N = clog2(NUM_CORES);
  localparam int unsigned IdxW  = (Log2N == 0) ? 1 : Log2N;
  localparam int unsigned BaseW = NONCE_W * NUM_CORES;

  sched_state_e            r_state, w_state_next;
  logic                    r_start_d;
  logic [NUM_CORES-1:0]    r_core_start, w_core_start_next;
  logic [BaseW-1:0]        r_core_base, w_core_base_next;
  logic                    r_core_abort, w_core_abort_next;
  logic [NONCE_W-1:0]      r_nonce, w_nonce_next;
  logic                    r_ticket, w_ticket_next;
  logic                    r_cmplt, w_cmplt_next;
  logic                    r_busy, w_busy_next;
  logic [NUM_CORES-1:0]    r_done_mask, w_done_mask_next;
  logic                    r_found_flag, w_found_flag_next;

  logic                    w_launch;
  logic [NUM_CORES-1:0]    w_done_acc;
  logic                    w_found_valid;
  logic [IdxW-1:0]         w_win_idx;
  logic [NONCE_W-1:0]      w_win_nonce;
  logic [NONCE_W-1:0]      w_nonce_adj;
  logic [BaseW-1:0]        w_base_calc;

  assign w_launch   = bus.start_hash & ~r_start_d;
  assign w_done_acc = r_done_mask | bus.core_done;

  lsb_priority_enc #(
    .Width (NUM_CORES),
    .IdxW  (IdxW)
  ) u_win_enc (
    .i_req   (bus.core_found),
    .o_valid (w_found_valid),
    .o_idx   (w_win_idx)
  );

  assign w_win_nonce = bus.core_nonce[NONCE_W*w_win_idx +: NONCE_W];

`ifdef HASH_SCHED_NONCE_ADJ_EN
  assign w_nonce_adj = w_win_nonce - NONCE_ADJ;
`else
  assign w_nonce_adj = w_win_nonce;
`endif

  // Slice i starts at i * 2^32 / NUM_CORES; a single core owns the whole space.
  always_comb begin
    w_base_calc = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (NUM_CORES > 1) begin
        w_base_calc[NONCE_W*i +: NONCE_W] = NONCE_W'(i) << (NONCE_W - Log2N);
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_core_start_next = '0;
    w_core_base_next  = r_core_base;
    w_core_abort_next = 1'b0;
    w_nonce_next      = r_nonce;
    w_ticket_next     = 1'b0;
    w_cmplt_next      = 1'b0;
    w_done_mask_next  = r_done_mask;
    w_found_flag_next = r_found_flag;

    if (bus.host_break) begin
      // Abort outranks launch, find and done; no result is reported.
      w_core_abort_next = (r_state == StDispatch) || (r_state == StRun);
      w_state_next      = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_launch) begin
            w_state_next      = StDispatch;
            w_core_start_next = '1;
            w_core_base_next  = w_base_calc;
            w_nonce_next      = '0;
            w_done_mask_next  = '0;
          end
        end
        StDispatch: begin
          w_state_next = StRun;
        end
        StRun: begin
          w_done_mask_next = w_done_acc;
          if (w_found_valid) begin
            w_nonce_next      = w_nonce_adj;
            w_core_abort_next = 1'b1;
            w_found_flag_next = 1'b1;
            w_state_next      = StReport;
          end else if (&w_done_acc) begin
            w_found_flag_next = 1'b0;
            w_state_next      = StReport;
          end
        end
        StReport: begin
          w_ticket_next = r_found_flag;
          w_cmplt_next  = ~r_found_flag;
          w_state_next  = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end

    w_busy_next = (w_state_next == StDispatch) || (w_state_next == StRun);
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_start_d    <= 1'b0;
      r_core_start <= '0;
      r_core_base  <= '0;
      r_core_abort <= 1'b0;
      r_nonce      <= '0;
      r_ticket     <= 1'b0;
      r_cmplt      <= 1'b0;
      r_busy       <= 1'b0;
      r_done_mask  <= '0;
      r_found_flag <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_start_d    <= bus.start_hash;
      r_core_start <= w_core_start_next;
      r_core_base  <= w_core_base_next;
      r_core_abort <= w_core_abort_next;
      r_nonce      <= w_nonce_next;
      r_ticket     <= w_ticket_next;
      r_cmplt      <= w_cmplt_next;
      r_busy       <= w_busy_next;
      r_done_mask  <= w_done_mask_next;
      r_found_flag <= w_found_flag_next;
    end
  end

  assign bus.core_start  = r_core_start;
  assign bus.core_base   = r_core_base;
  assign bus.core_abort  = r_core_abort;
  assign bus.nonce       = r_nonce;
  assign bus.ticket2moon = r_ticket;
  assign bus.hash_cmplt  = r_cmplt;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_hash_job_scheduler.sv
// Self-checking bench for hash_job_scheduler with NUM_CORES=4.
module tb_hash_job_scheduler;
  import hash_sched_pkg::*;

  localparam int unsigned N   = 4;
  localparam logic [31:0] ADJ = 32'h88;

  logic clk_h = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk_h = ~clk_h;

  hash_job_scheduler_if #(.NUM_CORES(N)) bus ();

  hash_job_scheduler #(
    .NUM_CORES (N),
    .NONCE_ADJ (ADJ)
  ) dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]   found;
    logic [3:0]   done;
    logic         brk;
    logic [127:0] nz;
    logic         e_abort;
    logic         e_ticket;
    logic         e_cmplt;
    logic [31:0]  e_nonce;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_nonce(input logic [31:0] raw);
`ifdef HASH_SCHED_NONCE_ADJ_EN
    return raw - ADJ;
`else
    return raw;
`endif
  endfunction

  function automatic logic [31:0] exp_base(input int unsigned i);
    logic [63:0] b;
    b = 64'(i) * (64'h1_0000_0000 / 64'(N));
    return b[31:0];
  endfunction

  task automatic step();
    @(posedge clk_h);
    #1;
  endtask

  task automatic clear_inputs();
    bus.core_found = '0;
    bus.core_done  = '0;
    bus.core_nonce = '0;
    bus.host_break = 1'b0;
  endtask

  // Raise start_hash; returns positioned in RUN cycle 0. Optional junk in DISPATCH.
  task automatic launch(input bit chk, input bit junk);
    bus.start_hash = 1'b1;
    step();
    bus.start_hash = 1'b0;
    if (chk) begin
      check("dispatch.core_start", 128'(bus.core_start), 128'(4'hF));
      check("dispatch.busy", 128'(bus.busy), 128'(1));
      for (int unsigned i = 0; i < N; i++) begin
        check($sformatf("dispatch.base%0d", i), 128'(bus.core_base[32*i +: 32]),
              128'(exp_base(i)));
      end
    end
    if (junk) begin
      bus.core_found = 4'($urandom);
      bus.core_done  = 4'($urandom);
      bus.core_nonce = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    clear_inputs();
    if (chk) begin
      check("run0.core_start", 128'(bus.core_start), 128'(0));
      check("run0.busy", 128'(bus.busy), 128'(1));
      check("run0.nonce", 128'(bus.nonce), 128'(0));
      check("run0.base3", 128'(bus.core_base[96 +: 32]), 128'(exp_base(3)));
    end
  endtask

  task automatic cleanup();
    bus.host_break = 1'b1;
    step();
    bus.host_break = 1'b0;
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".core_start"}, 128'(bus.core_start), 128'(0));
    check({tag, ".core_base"}, 128'(bus.core_base), 128'(0));
    check({tag, ".core_abort"}, 128'(bus.core_abort), 128'(0));
    check({tag, ".nonce"}, 128'(bus.nonce), 128'(0));
    check({tag, ".ticket2moon"}, 128'(bus.ticket2moon), 128'(0));
    check({tag, ".hash_cmplt"}, 128'(bus.hash_cmplt), 128'(0));
    check({tag, ".busy"}, 128'(bus.busy), 128'(0));
  endtask

  // Random job: the model resolves the whole job from the per-cycle pattern.
  task automatic random_job(input int job);
    logic [3:0]   fv[$];
    logic [3:0]   dv[$];
    logic [127:0] nv[$];
    logic [3:0]   mask;
    int           k;
    bit           is_found;
    logic [31:0]  want_nonce;
    int           len;

    len = $urandom_range(1, 12);
    for (int j = 0; j < len; j++) begin
      fv.push_back(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
      dv.push_back(4'($urandom & $urandom));
      nv.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    fv.push_back(4'h0);
    dv.push_back(4'hF);
    nv.push_back({$urandom, $urandom, $urandom, $urandom});

    mask = 4'h0;
    k = -1;
    is_found = 1'b0;
    want_nonce = 32'h0;
    for (int j = 0; j < fv.size() && k < 0; j++) begin
      if (fv[j] != 4'h0) begin
        for (int c = N - 1; c >= 0; c--) begin
          if (fv[j][c]) want_nonce = exp_nonce(nv[j][32*c +: 32]);
        end
        is_found = 1'b1;
        k = j;
      end else begin
        mask = mask | dv[j];
        if (mask == 4'hF) k = j;
      end
    end

    launch(1'b0, 1'b1);
    for (int j = 0; j <= k; j++) begin
      bus.core_found = fv[j];
      bus.core_done  = dv[j];
      bus.core_nonce = nv[j];
      step();
      check($sformatf("rnd%0d.c%0d.abort", job, j), 128'(bus.core_abort),
            128'(is_found && (j == k)));
      check($sformatf("rnd%0d.c%0d.busy", job, j), 128'(bus.busy), 128'(j != k));
      check($sformatf("rnd%0d.c%0d.results", job, j),
            128'({bus.ticket2moon, bus.hash_cmplt}), 128'(0));
    end
    clear_inputs();
    step();
    check($sformatf("rnd%0d.ticket2moon", job), 128'(bus.ticket2moon), 128'(is_found));
    check($sformatf("rnd%0d.hash_cmplt", job), 128'(bus.hash_cmplt), 128'(!is_found));
    check($sformatf("rnd%0d.nonce", job), 128'(bus.nonce), 128'(want_nonce));
    step();
    check($sformatf("rnd%0d.single_pulse", job),
          128'({bus.ticket2moon, bus.hash_cmplt, bus.busy}), 128'(0));
    check($sformatf("rnd%0d.nonce_held", job), 128'(bus.nonce), 128'(want_nonce));
  endtask

  initial begin
    bus.start_hash = 1'b0;
    clear_inputs();

    tbl[0] = '{4'b0100, 4'b0000, 1'b0, {32'h0, 32'h8000_1234, 32'h0, 32'h0},
               1'b1, 1'b1, 1'b0, exp_nonce(32'h8000_1234)};
    tbl[1] = '{4'b1010, 4'b0000, 1'b0, {32'hC000_0002, 32'h0, 32'h4000_0001, 32'h0},
               1'b1, 1'b1, 1'b0, exp_nonce(32'h4000_0001)};
    tbl[2] = '{4'b0011, 4'b1111, 1'b0, {32'h0, 32'h0, 32'h3333_4444, 32'h1111_2222},
               1'b1, 1'b1, 1'b0, exp_nonce(32'h1111_2222)};
    tbl[3] = '{4'b0000, 4'b1111, 1'b0, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
               1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4] = '{4'b0001, 4'b1111, 1'b1, {32'h0, 32'h0, 32'h0, 32'h1234_5678},
               1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{4'b0001, 4'b0000, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0000_0010},
               1'b1, 1'b1, 1'b0, exp_nonce(32'h0000_0010)};
    tbl[6] = '{4'b0000, 4'b0110, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0},
               1'b0, 1'b0, 1'b0, 32'h0};

    // Reset
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_reset");

    // Launch with base/start checks
    launch(1'b1, 1'b0);

    // Dones on cores 0,3,1,2 in separate cycles
    bus.core_done = 4'b0001; step();
    bus.core_done = 4'b1000; step();
    bus.core_done = 4'b0010; step();
    check("done_seq.busy_mid", 128'(bus.busy), 128'(1));
    bus.core_done = 4'b0100; step();
    clear_inputs();
    check("done_seq.d1", 128'({bus.hash_cmplt, bus.ticket2moon, bus.busy}), 128'(0));
    step();
    check("done_seq.d2.cmplt", 128'(bus.hash_cmplt), 128'(1));
    check("done_seq.d2.ticket", 128'(bus.ticket2moon), 128'(0));
    step();
    check("done_seq.d3.cmplt", 128'(bus.hash_cmplt), 128'(0));

    // Table-driven single-cycle events in RUN cycle 0
    for (int i = 0; i < 7; i++) begin
      launch(1'b0, 1'b0);
      bus.core_found = tbl[i].found;
      bus.core_done  = tbl[i].done;
      bus.core_nonce = tbl[i].nz;
      bus.host_break = tbl[i].brk;
      step();
      clear_inputs();
      check($sformatf("vec%0d.abort", i), 128'(bus.core_abort), 128'(tbl[i].e_abort));
      check($sformatf("vec%0d.nonce", i), 128'(bus.nonce), 128'(tbl[i].e_nonce));
      check($sformatf("vec%0d.early", i), 128'({bus.ticket2moon, bus.hash_cmplt}), 128'(0));
      step();
      check($sformatf("vec%0d.ticket", i), 128'(bus.ticket2moon), 128'(tbl[i].e_ticket));
      check($sformatf("vec%0d.cmplt", i), 128'(bus.hash_cmplt), 128'(tbl[i].e_cmplt));
      check($sformatf("vec%0d.abort_once", i), 128'(bus.core_abort), 128'(0));
      cleanup();
    end

    // start_hash re-rise while busy is ignored; a held level does not relaunch
    launch(1'b0, 1'b0);
    bus.start_hash = 1'b1; step();
    bus.start_hash = 1'b0; step();
    bus.start_hash = 1'b1; step();
    check("rerise.core_start", 128'(bus.core_start), 128'(0));
    check("rerise.busy", 128'(bus.busy), 128'(1));
    bus.core_done = 4'hF; step();
    clear_inputs(); step();
    check("rerise.cmplt", 128'(bus.hash_cmplt), 128'(1));
    step(); step();
    check("rerise.no_relaunch", 128'({bus.busy, bus.core_start}), 128'(0));
    bus.start_hash = 1'b0; step();

    // host_break together with a rising start in IDLE suppresses the launch
    bus.start_hash = 1'b1;
    bus.host_break = 1'b1;
    step();
    check("brk_idle.launch", 128'({bus.busy, bus.core_start, bus.core_abort}), 128'(0));
    bus.start_hash = 1'b0;
    bus.host_break = 1'b0;
    step();

    // Randomized jobs against the job-level model
    for (int job = 0; job < 40; job++) begin
      random_job(job);
      step();
    end

    // Asynchronous reset mid-RUN
    launch(1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    step();
    check("after_rst.busy", 128'(bus.busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hash_job_scheduler.md
# hash_job_scheduler

Distributes one hashing job across `NUM_CORES` parallel hash cores in the `clk_h` domain. Each core gets a disjoint slice of the 32-bit nonce space. The block collects the per-core found/done indications and arbitrates them into the single `nonce` / `ticket2moon` / `hash_cmplt` result path consumed by the USB3 interface. It sits between the interface's `start_hash` / `host_break` controls and the core array.

## Interface
Parameters:
- `NUM_CORES`, 4: number of hash cores; power of two, 1..16.
- `NONCE_ADJ`, 32'h88: pipeline offset subtracted from reported nonces when `HASH_SCHED_NONCE_ADJ_EN` is defined.

Ports:
- `clk_h` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_hash` in 1: level from interface; a rising edge launches a job.
- `host_break` in 1: abort the current job.
- `core_start` out `NUM_CORES`: one-cycle start pulse per core.
- `core_base` out `32*NUM_CORES`: nonce slice start per core; core i is at bits `[32*i+31:32*i]`.
- `core_abort` out 1: one-cycle pulse; all cores stop.
- `core_found` in `NUM_CORES`: one-cycle pulse; the core found a share.
- `core_done` in `NUM_CORES`: one-cycle pulse; the core exhausted its slice.
- `core_nonce` in `32*NUM_CORES`: nonce valid with `core_found[i]`.
- `nonce` out 32: winning nonce; held until the next job launch.
- `ticket2moon` out 1: one-cycle pulse; `nonce` is valid.
- `hash_cmplt` out 1: one-cycle pulse; all slices are exhausted with no find.
- `busy` out 1: high in DISPATCH or RUN.

## Operation
- States: IDLE, DISPATCH, RUN, REPORT.
- IDLE → DISPATCH on the `start_hash` rising edge. The edge is detected by registering `start_hash` as `start_d`; launch when `start_hash & ~start_d`.
- DISPATCH (one cycle):
  - `core_base[i] = i << (32 - log2(NUM_CORES))`; `NUM_CORES=1` gives base 0.
  - All `core_start` bits pulse together.
  - `done_mask` and `nonce` clear to 0.
  - → RUN.
- RUN:
  - `done_mask |= core_done`.
  - On any `core_found` bit: the lowest set index wins. Latch `nonce` from that core, pulse `core_abort`, → REPORT with `found_flag=1`.
  - Otherwise, when `done_mask` (including this cycle's `core_done`) is all ones → REPORT with `found_flag=0`.
  - Found takes priority over done in the same cycle.
- REPORT (one cycle): pulse `ticket2moon` if `found_flag`, else `hash_cmplt`. → IDLE.
- `host_break` in any state:
  - Pulse `core_abort` if the state was DISPATCH or RUN.
  - → IDLE. No result pulse. `nonce` is retained.
  - `host_break` beats a simultaneous find or done.
- `start_hash` rising while busy is ignored; a new job needs `start_hash` to drop and rise again.
- `core_found` / `core_done` outside RUN are ignored.
- Reset values: state IDLE; `core_start`, `core_abort`, `ticket2moon`, `hash_cmplt`, `busy` = 0; `nonce` = 0; `core_base` = 0; `done_mask` = 0; `start_d` = 0.

## Timing
- All outputs are registered.
- `start_hash` rises in cycle T → `core_start` and `core_base` valid in T+1 (DISPATCH).
- `core_found[i]` in cycle F:
  - `core_abort` and latched `nonce` valid at F+1.
  - `ticket2moon` at F+2.
- Last `core_done` in cycle D → `hash_cmplt` at D+2.
- `busy` is high from T+1 through the cycle before REPORT.
- `core_base` holds stable from DISPATCH until the next DISPATCH.

## Configuration
- `HASH_SCHED_NONCE_ADJ_EN` defined: latched `nonce = core_nonce[win] - NONCE_ADJ`, modulo 2^32 (wraps, e.g. 32'h10 → 32'hFFFFFF88).
- Undefined: `nonce = core_nonce[win]` unmodified; `NONCE_ADJ` is unused.

## Structure
- Shared package `hash_sched_pkg`:
  - state enum (IDLE=0, DISPATCH=1, RUN=2, REPORT=3);
  - `NONCE_W=32`;
  - a `clog2` helper.
- One sub-module `lsb_priority_enc`: `NUM_CORES` one-hot-or-multi input → valid + index of the lowest set bit. It drives the winner mux.

## Test plan
- Reset, then `NUM_CORES=4` and a `start_hash` rise → one-cycle `core_start`=4'b1111; bases 0, 0x40000000, 0x80000000, 0xC0000000; `busy`=1.
- `core_found`=4'b0100 with `core_nonce[2]`=0x8000_1234, macro off → `core_abort` at F+1; `ticket2moon` at F+2; `nonce`=0x8000_1234.
- `core_found`=4'b1010 in the same cycle, nonces 0x4000_0001 / 0xC000_0002 → `nonce`=0x4000_0001 (core 1 wins).
- `core_done` pulses on cores 0, 3, 1, 2 in separate cycles, with no find → single `hash_cmplt` two cycles after core 2's done; no `ticket2moon`.
- `host_break` in RUN, together with `core_found[0]` → `core_abort` pulse, IDLE; no `ticket2moon` / `hash_cmplt`; `nonce` unchanged.
- Macro on, `core_nonce[0]`=0x10 found → `nonce`=0xFFFFFF88. Separately, `rst_n` low mid-RUN → all outputs at reset values asynchronously.
